// File: rtl/ov7670_downscale.sv
// Crops a centred square from the camera capture pixel stream and box-averages it
// into an OUT_DIM x OUT_DIM luma image, emitting one write per output pixel.
module ov7670_downscale #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int OUT_DIM  = 28,
    parameter int BLK_LOG2 = 4,
    parameter int X0       = 96,
    parameter int Y0       = 16
) (
    input  logic       pclk,
    input  logic       rst_n,
    input  logic       vsync,
    input  logic       we_in,
    input  logic [7:0] din,
    output logic       out_we,
    output logic [9:0] out_addr,
    output logic [7:0] out_data,
    output logic       frame_done
);
    localparam int BLK   = 1 << BLK_LOG2;
    localparam int ACC_W = 2 * BLK_LOG2 + 8;
    localparam int BX_W  = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    localparam logic [9:0]      X_FIRST  = 10'(X0);
    localparam logic [9:0]      X_LAST   = 10'(IMG_W - 1);
    localparam logic [9:0]      WIN_X    = 10'(OUT_DIM * BLK);
    localparam logic [8:0]      Y_FIRST  = 9'(Y0);
    localparam logic [8:0]      Y_SAT    = 9'(IMG_H);
    localparam logic [8:0]      WIN_Y    = 9'(OUT_DIM * BLK);
    localparam logic [BX_W-1:0] BX_LAST  = BX_W'(OUT_DIM - 1);
    localparam logic [9:0]      ROW_STEP = 10'(OUT_DIM);
    localparam logic [9:0]      ROW_LAST = 10'((OUT_DIM - 1) * OUT_DIM);

    typedef enum logic {
        ST_WAIT,  // after reset or a finished frame: discard until vsync
        ST_RUN
    } state_t;

    state_t           state, state_nxt;
    logic [9:0]       x;
    logic [8:0]       y;
    logic [9:0]       cx;
    logic [8:0]       cy;
    logic [BX_W-1:0]  bx;
    logic [9:0]       row_base;
    logic [ACC_W-1:0] acc [OUT_DIM];
    logic [ACC_W-1:0] blk_sum;
    logic             pix_ok;
    logic             in_win;
    logic             blk_close;
    logic             last_blk;

    // Unsigned wrap makes columns/lines before the window compare as out of range.
    assign cx        = x - X_FIRST;
    assign cy        = y - Y_FIRST;
    assign bx        = cx[BLK_LOG2 +: BX_W];
    assign pix_ok    = (state == ST_RUN) && we_in && !vsync;
    assign in_win    = pix_ok && (cx < WIN_X) && (cy < WIN_Y);
    assign blk_close = in_win && (&cx[BLK_LOG2-1:0]) && (&cy[BLK_LOG2-1:0]);
    assign last_blk  = (row_base == ROW_LAST) && (bx == BX_LAST);
    assign blk_sum   = acc[bx] + ACC_W'(din);

    // NOTE: next state gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (vsync) begin
            state_nxt = ST_RUN;
        end else if (blk_close && last_blk) begin
            state_nxt = ST_WAIT;
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n || vsync) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
        end else if (pix_ok) begin
            if (x == X_LAST) begin
                x <= '0;
                if (y != Y_SAT) begin
                    y <= y + 9'd1;
                end
            end else begin
                x <= x + 10'd1;
            end
            if (blk_close && (bx == BX_LAST)) begin
                row_base <= row_base + ROW_STEP;
            end
        end
    end

    // NOTE: the accumulator array is cleared on reset and vsync; a stale partial sum would leak into the next frame.
    always_ff @(posedge pclk) begin
        if (!rst_n || vsync) begin
            for (int i = 0; i < OUT_DIM; i++) begin
                acc[i] <= '0;
            end
        end else if (in_win) begin
            acc[bx] <= blk_close ? '0 : blk_sum;
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            out_we     <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            out_we     <= blk_close;
            frame_done <= blk_close && last_blk;
            if (blk_close) begin
                out_addr <= row_base + 10'(bx);
                out_data <= blk_sum[ACC_W-1 -: 8];
            end
        end
    end

endmodule

// File: tb/tb_ov7670_downscale.sv
// Self-checking bench for ov7670_downscale on a reduced geometry, with a
// block-mean reference model computed directly from the generated image.
module tb_ov7670_downscale;
    localparam int IMG_W    = 56;
    localparam int IMG_H    = 52;
    localparam int OUT_DIM  = 3;
    localparam int BLK_LOG2 = 4;
    localparam int X0       = 5;
    localparam int Y0       = 3;
    localparam int BLK      = 1 << BLK_LOG2;
    localparam int NOUT     = OUT_DIM * OUT_DIM;
    localparam int CUT_LINE = 30;

    localparam int PAT_FLAT = 0;
    localparam int PAT_CROP = 1;
    localparam int PAT_AVG  = 2;
    localparam int PAT_RAND = 3;

    logic       pclk  = 1'b0;
    logic       rst_n = 1'b0;
    logic       vsync = 1'b0;
    logic       we_in = 1'b0;
    logic [7:0] din   = '0;
    logic       out_we;
    logic [9:0] out_addr;
    logic [7:0] out_data;
    logic       frame_done;

    ov7670_downscale #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_DIM(OUT_DIM),
        .BLK_LOG2(BLK_LOG2), .X0(X0), .Y0(Y0)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .we_in(we_in), .din(din),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data), .frame_done(frame_done)
    );

    always #5 pclk = ~pclk;

    logic [7:0] img [IMG_H][IMG_W];
    int         exp_pix [NOUT];
    logic [9:0] obs_addr [$];
    logic [7:0] obs_data [$];
    logic       obs_fd [$];
    int         fd_count = 0;
    int         n_checks = 0;
    int         n_fail   = 0;

    always @(negedge pclk) begin
        if (out_we === 1'b1) begin
            obs_addr.push_back(out_addr);
            obs_data.push_back(out_data);
            obs_fd.push_back(frame_done);
        end
        if (frame_done === 1'b1) fd_count++;
    end

    function automatic bit in_window(input int x, input int y);
        return (x >= X0) && (x < X0 + OUT_DIM * BLK) && (y >= Y0) && (y < Y0 + OUT_DIM * BLK);
    endfunction

    // Builds the frame and the expected image: each output is the truncated mean of its block.
    task automatic fill_image(input int pat, input logic [7:0] a, input logic [7:0] b);
        int sum;
        for (int y = 0; y < IMG_H; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                case (pat)
                    PAT_FLAT: img[y][x] = a;
                    PAT_CROP: img[y][x] = in_window(x, y) ? a : b;
                    PAT_AVG:  img[y][x] = in_window(x, y) ?
                                  8'(((x - X0) % BLK) * BLK + ((y - Y0) % BLK)) : 8'($urandom);
                    default:  img[y][x] = 8'($urandom);
                endcase
            end
        end
        for (int by = 0; by < OUT_DIM; by++) begin
            for (int bx = 0; bx < OUT_DIM; bx++) begin
                sum = 0;
                for (int j = 0; j < BLK; j++)
                    for (int i = 0; i < BLK; i++)
                        sum += int'(img[Y0 + by * BLK + j][X0 + bx * BLK + i]);
                exp_pix[by * OUT_DIM + bx] = sum / (BLK * BLK);
            end
        end
    endtask

    task automatic drive_vsync(input bit collide);
        @(negedge pclk);
        obs_addr.delete();
        obs_data.delete();
        obs_fd.delete();
        fd_count = 0;
        vsync    = 1'b1;
        we_in    = 1'b0;
        repeat (2) @(negedge pclk);
        if (collide) begin
            we_in = 1'b1;
            din   = ~img[0][0];
        end
        @(negedge pclk);
        vsync = 1'b0;
        we_in = 1'b0;
    endtask

    task automatic drive_pixels(input int y_from, input int y_to, input int density);
        for (int y = y_from; y < y_to; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                while (int'($urandom_range(99)) >= density) begin
                    we_in = 1'b0;
                    @(negedge pclk);
                end
                we_in = 1'b1;
                din   = img[y][x];
                @(negedge pclk);
            end
        end
        we_in = 1'b0;
        repeat (4) @(negedge pclk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vsync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            we_in = 1'(i & 1);
            din   = 8'($urandom);
            @(negedge pclk);
            n_checks++;
            if (out_we !== 1'b0 || out_addr !== 10'd0 || out_data !== 8'd0 || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got we=%b addr=%0d data=%0h done=%b, expected all 0",
                         i, out_we, out_addr, out_data, frame_done);
            end
        end
        we_in = 1'b0;
        rst_n = 1'b1;
        @(negedge pclk);
    endtask

    task automatic run_frame(input string name, input int pat, input logic [7:0] a,
                             input logic [7:0] b, input int density, input bit collide);
        fill_image(pat, a, b);
        drive_vsync(collide);
        drive_pixels(0, IMG_H, density);
        n_checks++;
        if (obs_addr.size() !== NOUT) begin
            n_fail++;
            $display("FAIL %s count: got %0d outputs, expected %0d", name, obs_addr.size(), NOUT);
        end
        foreach (obs_addr[i]) begin
            if (i < NOUT) begin
                n_checks++;
                if (obs_addr[i] !== 10'(i) || obs_data[i] !== 8'(exp_pix[i]) || obs_fd[i] !== (i == NOUT - 1)) begin
                    n_fail++;
                    $display("FAIL %s out[%0d]: got addr=%0d data=%0h done=%b, expected addr=%0d data=%0h done=%b",
                             name, i, obs_addr[i], obs_data[i], obs_fd[i], i, exp_pix[i], i == NOUT - 1);
                end
            end
        end
        n_checks++;
        if (fd_count !== 1) begin
            n_fail++;
            $display("FAIL %s frame_done: got %0d pulses, expected 1", name, fd_count);
        end
        n_checks++;
        if (out_addr !== 10'(NOUT - 1) || out_data !== 8'(exp_pix[NOUT - 1])) begin
            n_fail++;
            $display("FAIL %s hold: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                     name, out_addr, out_data, NOUT - 1, exp_pix[NOUT - 1]);
        end
    endtask

    task automatic test_abort();
        int exp_cnt;
        exp_cnt = ((CUT_LINE - Y0) / BLK) * OUT_DIM;
        fill_image(PAT_RAND, 8'h00, 8'h00);
        drive_vsync(1'b0);
        drive_pixels(0, CUT_LINE, 75);
        n_checks++;
        if (fd_count !== 0) begin
            n_fail++;
            $display("FAIL abort frame_done: got %0d pulses, expected 0", fd_count);
        end
        n_checks++;
        if (obs_addr.size() !== exp_cnt) begin
            n_fail++;
            $display("FAIL abort count: got %0d outputs, expected %0d", obs_addr.size(), exp_cnt);
        end
        run_frame("abort_next", PAT_FLAT, 8'h40, 8'h00, 75, 1'b0);
    endtask

    task automatic test_midframe_reset();
        fill_image(PAT_RAND, 8'h00, 8'h00);
        drive_vsync(1'b0);
        drive_pixels(0, CUT_LINE, 75);
        rst_n = 1'b0;
        repeat (2) @(negedge pclk);
        n_checks++;
        if (out_we !== 1'b0 || out_addr !== 10'd0 || out_data !== 8'd0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset outputs: got we=%b addr=%0d data=%0h done=%b, expected all 0",
                     out_we, out_addr, out_data, frame_done);
        end
        rst_n = 1'b1;
        obs_addr.delete();
        obs_data.delete();
        obs_fd.delete();
        fd_count = 0;
        drive_pixels(CUT_LINE, IMG_H, 75);
        n_checks++;
        if (obs_addr.size() !== 0 || fd_count !== 0) begin
            n_fail++;
            $display("FAIL midreset discard: got %0d outputs %0d done pulses, expected 0 and 0",
                     obs_addr.size(), fd_count);
        end
        run_frame("reset_next", PAT_RAND, 8'h00, 8'h00, 75, 1'b0);
    endtask

    initial begin
        test_reset();
        run_frame("flat", PAT_FLAT, 8'h80, 8'h00, 50, 1'b0);
        run_frame("crop_in00", PAT_CROP, 8'h00, 8'hFF, 75, 1'b0);
        run_frame("crop_inFF", PAT_CROP, 8'hFF, 8'h00, 75, 1'b0);
        run_frame("average", PAT_AVG, 8'h00, 8'h00, 75, 1'b0);
        run_frame("back_to_back", PAT_RAND, 8'h00, 8'h00, 100, 1'b0);
        test_abort();
        run_frame("vsync_collide", PAT_RAND, 8'h00, 8'h00, 75, 1'b1);
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ov7670_downscale.md
Name: ov7670_downscale

Overview:
- Sits directly downstream of the camera capture stage, on the same pixel clock.
- Consumes the capture stage's raster-order pixel write stream (write strobe plus 8-bit luma byte) and crops a centred square window.
- Box-averages that window by 2^BLK_LOG2 x 2^BLK_LOG2 blocks into an OUT_DIM x OUT_DIM 8-bit image for the CNN input buffer.
- Emits one write per output pixel and a frame-done pulse once the last output pixel is written.

Parameters:
- IMG_W, 640, active pixels per line of the incoming stream
- IMG_H, 480, active lines per frame
- OUT_DIM, 28, output image width and height in pixels
- BLK_LOG2, 4, log2 of block edge; block = 16x16 = 256 input pixels
- X0, 96, first cropped column; X0 + OUT_DIM*2^BLK_LOG2 <= IMG_W
- Y0, 16, first cropped line; Y0 + OUT_DIM*2^BLK_LOG2 <= IMG_H

Ports:
- pclk  in  1  pixel clock, all logic on its rising edge
- rst_n  in  1  synchronous active-low reset
- vsync  in  1  frame sync from camera; high = between frames
- we_in  in  1  pixel strobe from capture stage; one pixel per high cycle
- din  in  8  pixel byte, valid when we_in=1
- out_we  out  1  output pixel write strobe
- out_addr  out  10  output address, row-major: by*OUT_DIM+bx, range 0..783
- out_data  out  8  averaged pixel
- frame_done  out  1  one-cycle pulse, frame complete

Behaviour:
- Reset (rst_n=0 at a pclk edge): x=0, y=0, all accumulators 0, out_we=0, out_addr=0, out_data=0, frame_done=0. Reset applies mid-frame; data arriving before the next vsync is discarded, same as after vsync.
- Position counters: x (10b), y (9b). On we_in=1: if x==IMG_W-1 then x<=0, y<=y+1, else x<=x+1. y saturates at IMG_H; pixels with y>=IMG_H are ignored. No output is produced for them.
- vsync=1: x, y and all accumulators cleared, block state idle. vsync has priority over a simultaneous we_in, and that pixel is dropped. An incomplete frame never raises frame_done.
- Crop: pixel in window iff X0<=x<X0+OUT_DIM*16 and Y0<=y<Y0+OUT_DIM*16. Let cx=x-X0, cy=y-Y0, bx=cx>>4, by=cy>>4. Pixels outside the window are ignored.
- Accumulation: OUT_DIM column accumulators acc[0..OUT_DIM-1], each BLK_LOG2*2+8 = 16 bits, no overflow possible. On an in-window pixel, acc[bx] += din.
- Block completion: when cx[3:0]==15 and cy[3:0]==15, the block closes. Next cycle: out_we=1, out_data=(acc[bx]+din)>>8 (truncating), out_addr=by*OUT_DIM+bx. In the same cycle as the update, acc[bx] is cleared to 0 rather than updated.
- Latency: exactly 1 pclk from the closing we_in to out_we.
- out_we is high for a single cycle per output. out_addr and out_data hold their last values when out_we=0.
- Outputs within a frame appear in strictly increasing address order 0..OUT_DIM^2-1.
- frame_done=1 in the same cycle as the out_we carrying address OUT_DIM^2-1, otherwise 0. At most once per frame.
- Back-to-back we_in on consecutive cycles must be accepted with no stall; there is no backpressure.
- Address arithmetic uses an incrementing row base (by*OUT_DIM), not a multiplier.

Test Plan:
- Reset: hold rst_n=0 for 4 cycles with we_in toggling -> all outputs 0, no out_we.
- Flat frame: vsync pulse, then 640x480 pixels of 0x80 with we_in alternating per capture cadence -> exactly 784 out_we, addresses 0..783 in order, all data 0x80, one frame_done coincident with addr 783.
- Crop check: pixels inside the window 0x00, outside 0xFF -> all 784 outputs 0x00. Then swap the values -> all 0xFF.
- Averaging and truncation: inside each block, pixel = cx[3:0]*16+cy[3:0] (values 0..255, sum 32640) -> every output 0x7F (127, truncated from 127.5).
- Abort: vsync asserted after line 200, then a full flat 0x40 frame -> no frame_done for the aborted frame. The following frame gives 784 outputs of 0x40 with no contamination from stale accumulators.
- Simultaneous vsync+we_in and mid-frame rst_n: the pixel with vsync high is not counted (next frame's first output unchanged). rst_n low at line 300 -> out_we stays 0 until the next full frame, which completes normally.
